// File: rtl/pattern_det_ctrl.sv
// pattern_det_ctrl: programmable serial pattern detector with IDLE/RUN/DONE sequencing and match counting.
// Define PATDET_BITCNT_EN to add the 16-bit bit_cnt output (valid bits sampled in RUN).
module pattern_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_wr,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               data_valid,
    input  logic               data_in,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
`ifdef PATDET_BITCNT_EN
    ,
    output logic [15:0]        bit_cnt
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d, pat_q, pat_d;
    logic [LEN_W-1:0]   fill_q, fill_d, len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   tgt_q, tgt_d, cnt_q, cnt_d;
    logic               match_q, match_d, busy_q, busy_d;
    logic               done_q, done_d, cfg_err_q, cfg_err_d;
    logic [MAX_LEN-1:0] hist_nx, len_mask;
    logic [LEN_W-1:0]   fill_nx;
    logic [CNT_W-1:0]   cnt_inc;
    logic               hit, cfg_ok;
`ifdef PATDET_BITCNT_EN
    logic [15:0]        bitcnt_q, bitcnt_d;
`endif

    function automatic logic [MAX_LEN-1:0] mask_of(input logic [LEN_W-1:0] l);
        logic [MAX_LEN-1:0] m;
        m = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            m[i] = (i < int'(l));
        end
        return m;
    endfunction

    // Candidate shift/fill values and the match decision for the current bit.
    always_comb begin
        hist_nx  = {hist_q[MAX_LEN-2:0], data_in};
        fill_nx  = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + LEN_W'(1);
        len_mask = mask_of(len_q);
        hit      = (fill_nx >= len_q) && ((hist_nx & len_mask) == (pat_q & len_mask));
        cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        cfg_ok   = (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= LEN_MAX);
    end

    // Next-state, configuration, sampling and output decode.
    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        match_d   = 1'b0;
        cfg_err_d = 1'b0;
`ifdef PATDET_BITCNT_EN
        bitcnt_d  = bitcnt_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (cfg_wr && cfg_ok) begin
                    pat_d = cfg_pattern;
                    len_d = cfg_len;
                    ovl_d = cfg_overlap;
                    tgt_d = cfg_target;
                end else if (cfg_wr) begin
                    cfg_err_d = 1'b1;
                end else begin
                    cfg_err_d = 1'b0;
                end
                // Abort beats a simultaneous start; nothing is cleared then.
                if (start && abort) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                    hist_d  = {MAX_LEN{1'b0}};
                    fill_d  = {LEN_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
`ifdef PATDET_BITCNT_EN
                    bitcnt_d = 16'd0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (data_valid) begin
                    hist_d = hist_nx;
                    fill_d = fill_nx;
`ifdef PATDET_BITCNT_EN
                    bitcnt_d = (bitcnt_q == 16'hFFFF) ? bitcnt_q : bitcnt_q + 16'd1;
`endif
                    if (hit) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_inc;
                        if (!ovl_q) begin
                            fill_d = {LEN_W{1'b0}};
                        end else begin
                            fill_d = fill_nx;
                        end
                        if ((tgt_q != {CNT_W{1'b0}}) && (cnt_inc == tgt_q)) begin
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        match_d = 1'b0;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            hist_q    <= {MAX_LEN{1'b0}};
            fill_q    <= {LEN_W{1'b0}};
            pat_q     <= MAX_LEN'(3'b101);
            len_q     <= LEN_W'(3);
            ovl_q     <= 1'b1;
            tgt_q     <= {CNT_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            match_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
`ifdef PATDET_BITCNT_EN
            bitcnt_q  <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
`ifdef PATDET_BITCNT_EN
            bitcnt_q  <= bitcnt_d;
`endif
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
`ifdef PATDET_BITCNT_EN
    assign bit_cnt   = bitcnt_q;
`endif

endmodule
